bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 tb/tb_bin2bcd_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a host and the binary-to-BCD converter
interface bin2bcd_seq_if;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  d1;
  logic [3:0]  d2;
  logic [3:0]  d3;
  logic [3:0]  d4;

  modport master (
    output start, bin,
    input  busy, done, ovf, d1, d2, d3, d4
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, d1, d2, d3, d4
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter (shift-add-3), saturating at 9999
module bin2bcd_seq (
  input  logic          clk,
  input  logic          clr,
  bin2bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [13:0] op_q;
  logic [15:0] scratch_q;
  logic [3:0]  cnt_q;
  logic        pend_ovf_q;
  logic        done_q;
  logic        ovf_q;
  logic [3:0]  d1_q, d2_q, d3_q, d4_q;
  logic [15:0] adj_d;

  // Add-3 correction applied to every BCD nibble of 5 or more before the shift
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Control FSM, datapath and committed display registers; digits only change on commit
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      op_q       <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      pend_ovf_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      d4_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Amounts above four digits are clamped so the display reads 9999 with ovf set
            if (bus.bin > 14'd9999) begin
              op_q       <= 14'd9999;
              pend_ovf_q <= 1'b1;
            end else begin
              op_q       <= bus.bin;
              pend_ovf_q <= 1'b0;
            end
            scratch_q <= '0;
            cnt_q     <= 4'd14;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= {adj_d[14:0], op_q[13]};
          op_q      <= {op_q[12:0], 1'b0};
          cnt_q     <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          d1_q    <= scratch_q[3:0];
          d2_q    <= scratch_q[7:4];
          d3_q    <= scratch_q[11:8];
          d4_q    <= scratch_q[15:12];
          ovf_q   <= pend_ovf_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.d1   = d1_q;
  assign bus.d2   = d2_q;
  assign bus.d3   = d3_q;
  assign bus.d4   = d4_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic clk;
  logic clr;
  int   n_vec;
  int   n_err;
  int   pulses;

  bin2bcd_seq_if ifc ();

  bin2bcd_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  function automatic logic [15:0] digits();
    return {ifc.d4, ifc.d3, ifc.d2, ifc.d1};
  endfunction

  // Saturated decimal expectation {ovf, thousands, hundreds, tens, ones}
  function automatic logic [16:0] model(input int b);
    int s;
    s = (b > 9999) ? 9999 : b;
    return {(b > 9999), 4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Full conversion from IDLE: accept at edge 0, check edges 14, 15 and 16
  task automatic run_conv(input string tag, input logic [13:0] b,
                          input logic [15:0] exp_d, input logic exp_ovf);
    ifc.start = 1'b1;
    ifc.bin   = b;
    step();
    ifc.start = 1'b0;
    chk({tag, " busy_e0"}, ifc.busy, 1);
    for (int k = 1; k <= 14; k++) step();
    chk({tag, " done_e14"}, ifc.done, 0);
    step();
    chk({tag, " done_e15"}, ifc.done, 1);
    chk({tag, " digits"}, digits(), exp_d);
    chk({tag, " ovf"}, ifc.ovf, exp_ovf);
    step();
    chk({tag, " done_e16"}, ifc.done, 0);
    chk({tag, " busy_e16"}, ifc.busy, 0);
  endtask

  initial begin
    logic [16:0] m;
    int          v;
    n_vec     = 0;
    n_err     = 0;
    clr       = 1'b0;
    ifc.start = 1'b0;
    ifc.bin   = '0;
    step();
    step();
    chk("rst busy", ifc.busy, 0);
    chk("rst done", ifc.done, 0);
    chk("rst ovf", ifc.ovf, 0);
    chk("rst digits", digits(), 16'h0000);

    // Reset coincident with start: start must not be taken
    ifc.start = 1'b1;
    ifc.bin   = 14'd77;
    step();
    clr       = 1'b1;
    ifc.start = 1'b0;
    chk("clr_vs_start busy", ifc.busy, 0);
    step();
    chk("clr_vs_start busy2", ifc.busy, 0);

    run_conv("bin0", 14'd0, 16'h0000, 1'b0);
    run_conv("bin1234", 14'd1234, 16'h1234, 1'b0);
    run_conv("bin9999", 14'd9999, 16'h9999, 1'b0);
    run_conv("bin12000", 14'd12000, 16'h9999, 1'b1);
    run_conv("bin5", 14'd5, 16'h0005, 1'b0);
    run_conv("bin250", 14'd250, 16'h0250, 1'b0);

    // Extra starts with a different operand while busy are ignored
    ifc.start = 1'b1;
    ifc.bin   = 14'd4321;
    step();
    ifc.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3 || k == 9) begin
        ifc.start = 1'b1;
        ifc.bin   = 14'd7;
      end
      step();
      ifc.start = 1'b0;
      if (k == 3 || k == 9 || k == 14) begin
        chk($sformatf("hold250 e%0d", k), digits(), 16'h0250);
        chk($sformatf("busy4321 e%0d", k), ifc.busy, 1);
      end
    end
    step();
    chk("bin4321 done", ifc.done, 1);
    chk("bin4321 digits", digits(), 16'h4321);
    step();
    chk("bin4321 busy_e16", ifc.busy, 0);
    step();
    chk("noqueue busy", ifc.busy, 0);

    // Reset mid-conversion aborts with no done pulse
    ifc.start = 1'b1;
    ifc.bin   = 14'd8765;
    step();
    ifc.start = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    clr = 1'b0;
    step();
    clr = 1'b1;
    chk("abort digits", digits(), 16'h0000);
    chk("abort ovf", ifc.ovf, 0);
    chk("abort busy", ifc.busy, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (ifc.done) pulses++;
      step();
    end
    chk("abort no_done", pulses, 0);
    run_conv("bin42", 14'd42, 16'h0042, 1'b0);

    // Back-to-back sweep with start held high; operand walks all residues mod 4
    ifc.start = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      v       = 4 * k + (k & 3);
      ifc.bin = 14'(v);
      step();
      ifc.bin = 14'(4 * (k + 1) + ((k + 1) & 3));
      for (int e = 1; e <= 14; e++) step();
      chk($sformatf("sweep %0d done_e14", v), ifc.done, 0);
      step();
      m = model(v);
      chk($sformatf("sweep %0d done", v), ifc.done, 1);
      chk($sformatf("sweep %0d result", v), {ifc.ovf, digits()}, m);
    end
    ifc.start = 1'b0;
    step();
    chk("sweep end done", ifc.done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
